// File: rtl/bw_io_impctl_upclk_gen.sv
// Impedance-controller update-clock generator: one-shot settle, bypass, then periodic update.
// Optional `IMPCTL_UPD_STATS_EN adds a saturating update counter output (upd_count).
module bw_io_impctl_upclk_gen #(
    parameter int CNT_W     = 8,
    parameter int OS_TC     = 15,
    parameter int BYP_TICKS = 64,
    parameter int AVG_TAP   = 5
) (
    input  logic             l2clk,
    input  logic             reset,
    input  logic             int_sclk,
    input  logic             synced_upd_imped,
    input  logic             rearm,
    input  logic [CNT_W-1:0] period_tc,
    output logic             updclk,
    output logic             bypass,
    output logic             oe_out,
    output logic             avgcntr_rst,
    output logic             cnt_rst,
    output logic [1:0]       state
`ifdef IMPCTL_UPD_STATS_EN
    ,
    output logic [15:0]      upd_count
`endif
);

    typedef enum logic [1:0] {
        ONESHOT = 2'b00,
        BYPASS  = 2'b01,
        NORMAL  = 2'b10
    } state_t;

    localparam int BYP_W = (BYP_TICKS > 0) ? $clog2(BYP_TICKS + 1) : 1;
    localparam logic [CNT_W-1:0]   OS_LAST  = CNT_W'(OS_TC);
    localparam logic [BYP_W-1:0]   BYP_LAST = BYP_W'((BYP_TICKS > 0) ? (BYP_TICKS - 1) : 0);
    localparam logic [AVG_TAP:0]   AVG_ONES = '1;
    localparam bit                 BYP_EXIT = (BYP_TICKS > 0);

    state_t             cur_state;
    state_t             nxt_state;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   nxt_cnt;
    logic [BYP_W-1:0]   byp_cnt;
    logic [BYP_W-1:0]   nxt_byp;
    logic               nxt_upd;
    logic               nxt_avg;
    logic               nxt_crst;
    logic               tick;
    logic               avg_hit;

    assign tick    = int_sclk;
    assign avg_hit = tick && (cnt[AVG_TAP:0] == AVG_ONES);

    always_ff @(posedge l2clk or posedge reset) begin
        if (reset) begin
            cur_state   <= ONESHOT;
            cnt         <= '0;
            byp_cnt     <= '0;
            updclk      <= 1'b0;
            bypass      <= 1'b0;
            avgcntr_rst <= 1'b0;
            cnt_rst     <= 1'b0;
        end else begin
            cur_state   <= nxt_state;
            cnt         <= nxt_cnt;
            byp_cnt     <= nxt_byp;
            updclk      <= nxt_upd;
            bypass      <= (nxt_state == BYPASS);
            avgcntr_rst <= nxt_avg;
            cnt_rst     <= nxt_crst;
        end
    end

    // Clears take priority over the phase sequencing; a suppressed tick is simply dropped.
    always_comb begin
        nxt_state = cur_state;
        nxt_cnt   = cnt;
        nxt_byp   = byp_cnt;
        nxt_upd   = 1'b0;
        nxt_avg   = 1'b0;
        nxt_crst  = 1'b0;
        if (rearm) begin
            nxt_state = ONESHOT;
            nxt_cnt   = '0;
            nxt_byp   = '0;
            nxt_crst  = 1'b1;
        end else if (synced_upd_imped) begin
            nxt_cnt  = '0;
            nxt_crst = 1'b1;
        end else begin
            nxt_avg = avg_hit;
            if (tick) begin
                case (cur_state)
                    ONESHOT: begin
                        if (cnt == OS_LAST) begin
                            nxt_state = BYPASS;
                            nxt_cnt   = '0;
                            nxt_crst  = 1'b1;
                        end else begin
                            nxt_cnt = cnt + CNT_W'(1);
                        end
                    end
                    BYPASS: begin
                        nxt_upd = 1'b1;
                        if (BYP_EXIT && (byp_cnt == BYP_LAST)) begin
                            nxt_state = NORMAL;
                            nxt_cnt   = '0;
                            nxt_byp   = '0;
                            nxt_crst  = 1'b1;
                        end else begin
                            nxt_cnt = cnt + CNT_W'(1);
                            nxt_byp = byp_cnt + BYP_W'(1);
                        end
                    end
                    NORMAL: begin
                        // Equality only: lowering period_tc below cnt lets cnt wrap silently.
                        if (cnt == period_tc) begin
                            nxt_cnt = '0;
                            nxt_upd = 1'b1;
                        end else begin
                            nxt_cnt = cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        nxt_state = ONESHOT;
                        nxt_cnt   = '0;
                        nxt_byp   = '0;
                        nxt_crst  = 1'b1;
                    end
                endcase
            end
        end
    end

    assign oe_out = bypass | ~(cnt[CNT_W-1] & cnt[CNT_W-2]);
    assign state  = cur_state;

`ifdef IMPCTL_UPD_STATS_EN
    always_ff @(posedge l2clk or posedge reset) begin
        if (reset) begin
            upd_count <= '0;
        end else if (rearm) begin
            upd_count <= '0;
        end else if (updclk && (upd_count != 16'hFFFF)) begin
            upd_count <= upd_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bw_io_impctl_upclk_gen.sv
// Bench for bw_io_impctl_upclk_gen: directed vector table, sequence checks and random vs. model.
module tb_bw_io_impctl_upclk_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b0, sclk = 1'b0, upd = 1'b0, rearm = 1'b0;
    logic [7:0] ptc = 8'd3;
    logic       updclk, bypass, oe, avg, crst;
    logic [1:0] st;

    logic       rst1 = 1'b0, sclk1 = 1'b0, upd1 = 1'b0, rearm1 = 1'b0;
    logic [7:0] ptc1 = 8'd3;
    logic       updclk1, bypass1, oe1, avg1, crst1;
    logic [1:0] st1;

`ifdef IMPCTL_UPD_STATS_EN
    logic [15:0] ucnt, ucnt1;
`endif

    bw_io_impctl_upclk_gen dut (
        .l2clk(clk), .reset(rst), .int_sclk(sclk), .synced_upd_imped(upd), .rearm(rearm),
        .period_tc(ptc), .updclk(updclk), .bypass(bypass), .oe_out(oe), .avgcntr_rst(avg),
        .cnt_rst(crst), .state(st)
`ifdef IMPCTL_UPD_STATS_EN
        , .upd_count(ucnt)
`endif
    );

    bw_io_impctl_upclk_gen #(.BYP_TICKS(0)) dut_nobyp (
        .l2clk(clk), .reset(rst1), .int_sclk(sclk1), .synced_upd_imped(upd1), .rearm(rearm1),
        .period_tc(ptc1), .updclk(updclk1), .bypass(bypass1), .oe_out(oe1), .avgcntr_rst(avg1),
        .cnt_rst(crst1), .state(st1)
`ifdef IMPCTL_UPD_STATS_EN
        , .upd_count(ucnt1)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d expected=%0d at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: phase 0/1/2, plain integer counters.
    int m_phase, m_cnt, m_bc;
    bit m_upd, m_avg, m_crst;

    function automatic void model_reset();
        m_phase = 0; m_cnt = 0; m_bc = 0;
        m_upd = 0; m_avg = 0; m_crst = 0;
    endfunction

    function automatic void model_step();
        if (rst) begin
            model_reset();
            return;
        end
        m_upd = 0; m_avg = 0; m_crst = 0;
        if (rearm) begin
            m_phase = 0; m_cnt = 0; m_bc = 0; m_crst = 1;
        end else if (upd) begin
            m_cnt = 0; m_crst = 1;
        end else begin
            m_avg = sclk && ((m_cnt % 64) == 63);
            if (sclk) begin
                if (m_phase == 0) begin
                    if (m_cnt == 15) begin m_phase = 1; m_cnt = 0; m_crst = 1; end
                    else m_cnt = (m_cnt + 1) % 256;
                end else if (m_phase == 1) begin
                    m_upd = 1;
                    if (m_bc == 63) begin m_phase = 2; m_cnt = 0; m_bc = 0; m_crst = 1; end
                    else begin m_cnt = (m_cnt + 1) % 256; m_bc = m_bc + 1; end
                end else begin
                    if (m_cnt == int'(ptc)) begin m_cnt = 0; m_upd = 1; end
                    else m_cnt = (m_cnt + 1) % 256;
                end
            end
        end
    endfunction

    task automatic check_all();
        chk("state", {30'd0, st}, m_phase);
        chk("updclk", updclk, m_upd);
        chk("bypass", bypass, m_phase == 1);
        chk("oe_out", oe, (m_phase == 1) || (m_cnt < 192));
        chk("avgcntr_rst", avg, m_avg);
        chk("cnt_rst", crst, m_crst);
    endtask

    task automatic run_cycle();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    typedef struct {
        int       cycles;
        bit       sclk;
        bit       upd;
        bit       rearm;
        bit [1:0] st;
        bit       updclk;
        bit       crst;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(int c, bit s, bit u, bit r, bit [1:0] est, bit eu, bit ec);
        vec_t v;
        v.cycles = c; v.sclk = s; v.upd = u; v.rearm = r;
        v.st = est; v.updclk = eu; v.crst = ec;
        tbl.push_back(v);
    endfunction

    initial begin
        int n, n2;
        // startup / bypass / normal(period 4) / update-request / rearm sequence from reset
        add(15, 1, 0, 0, 2'd0, 0, 0);
        add(1,  1, 0, 0, 2'd1, 0, 1);
        add(1,  1, 0, 0, 2'd1, 1, 0);
        add(62, 1, 0, 0, 2'd1, 1, 0);
        add(1,  1, 0, 0, 2'd2, 1, 1);
        add(1,  1, 0, 0, 2'd2, 0, 0);
        add(3,  1, 0, 0, 2'd2, 1, 0);
        add(1,  1, 0, 0, 2'd2, 0, 0);
        add(2,  1, 0, 0, 2'd2, 0, 0);
        add(1,  1, 1, 0, 2'd2, 0, 1);
        add(4,  1, 0, 0, 2'd2, 1, 0);
        add(1,  0, 0, 0, 2'd2, 0, 0);
        add(1,  1, 0, 1, 2'd0, 0, 1);
        add(15, 1, 0, 0, 2'd0, 0, 0);
        add(1,  1, 0, 0, 2'd1, 0, 1);
        add(20, 1, 0, 0, 2'd1, 1, 0);
        add(1,  1, 0, 1, 2'd0, 0, 1);
        add(15, 1, 0, 0, 2'd0, 0, 0);
        add(1,  1, 0, 0, 2'd1, 0, 1);

        #2 rst = 1'b1;
        #1 model_reset();
        check_all();
        run_cycle();
        run_cycle();
        rst = 1'b0;

        foreach (tbl[i]) begin
            sclk = tbl[i].sclk; upd = tbl[i].upd; rearm = tbl[i].rearm;
            repeat (tbl[i].cycles) run_cycle();
            chk($sformatf("vec%0d_state", i), {30'd0, st}, tbl[i].st);
            chk($sformatf("vec%0d_updclk", i), updclk, tbl[i].updclk);
            chk($sformatf("vec%0d_cnt_rst", i), crst, tbl[i].crst);
        end
        upd = 1'b0; rearm = 1'b0; sclk = 1'b1;

        // finish bypass, then 100 periods of 4 ticks
        repeat (64) run_cycle();
        chk("enter_normal", {30'd0, st}, 2);
        n = 0;
        repeat (400) begin
            run_cycle();
            if (updclk) n++;
        end
        chk("period4_pulses", n, 100);

        // full 256-tick period: oe low on the top quarter, avg reset every 64 ticks
        ptc = 8'd255;
        n = 0; n2 = 0;
        repeat (512) begin
            run_cycle();
            if (avg) n++;
            if (!oe) n2++;
        end
        chk("avg_pulses", n, 8);
        chk("oe_low_cycles", n2, 128);

        ptc = 8'd3;
        for (int i = 0; i < 3000; i++) begin
            sclk  = ($urandom_range(0, 3) != 0);
            upd   = ($urandom_range(0, 39) == 0);
            rearm = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 199) == 0)
                ptc = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(0, 255));
            run_cycle();
            if ($urandom_range(0, 999) == 0) begin
                #3 rst = 1'b1;
                #1 model_reset();
                check_all();
                run_cycle();
                rst = 1'b0;
            end
        end
        sclk = 1'b0; upd = 1'b0; rearm = 1'b0;

        // BYP_TICKS=0: bypass holds forever; async reset mid-period
        @(posedge clk); #3 rst1 = 1'b1;
        @(posedge clk); #1 rst1 = 1'b0; sclk1 = 1'b1;
        repeat (16) @(posedge clk);
        #1 chk("nobyp_enter_bypass", {30'd0, st1}, 1);
        n = 0;
        repeat (200) begin
            @(posedge clk); #1;
            if (st1 != 2'd1 || !updclk1) n++;
        end
        chk("nobyp_stays_bypass", n, 0);
        @(posedge clk); #3;
        chk("nobyp_pre_updclk", updclk1, 1);
        chk("nobyp_pre_bypass", bypass1, 1);
        rst1 = 1'b1;
        #1;
        chk("async_rst_state", {30'd0, st1}, 0);
        chk("async_rst_updclk", updclk1, 0);
        chk("async_rst_bypass", bypass1, 0);
        chk("async_rst_oe", oe1, 1);
        chk("async_rst_avg", avg1, 0);
        chk("async_rst_cnt_rst", crst1, 0);
        @(posedge clk); #1;
        chk("async_rst_hold_updclk", updclk1, 0);
        rst1 = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
